// File: rtl/axis_mem_write_arbiter.sv
// Packet-level 2:1 round-robin arbiter feeding one AXI-Stream write port.
// A grant is held from the first beat until the tlast handshake, so packets never interleave.
module axis_mem_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    axis_aclk,
    input  logic                    axis_areset,
    input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s00_axis_tstrb,
    input  logic                    s00_axis_tvalid,
    input  logic                    s00_axis_tlast,
    output logic                    s00_axis_tready,
    input  logic [DATA_WIDTH-1:0]   s01_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
    input  logic                    s01_axis_tvalid,
    input  logic                    s01_axis_tlast,
    output logic                    s01_axis_tready,
    output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                    m00_axis_tvalid,
    output logic                    m00_axis_tlast,
    input  logic                    m00_axis_tready,
    output logic [1:0]              grant,
    output logic [CNT_WIDTH-1:0]    pkt_count0,
    output logic [CNT_WIDTH-1:0]    pkt_count1
);

    // The one-hot grant doubles as the state encoding.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t     state_reg;
    state_t     state_next;
    logic       last_owner_reg;
    logic       last_owner_next;
    logic [1:0] pkt_done;

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            state_reg      <= IDLE;
            last_owner_reg <= 1'b1;
        end else begin
            state_reg      <= state_next;
            last_owner_reg <= last_owner_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        last_owner_next = last_owner_reg;
        pkt_done        = 2'b00;
        s00_axis_tready = 1'b0;
        s01_axis_tready = 1'b0;
        m00_axis_tdata  = '0;
        m00_axis_tstrb  = '0;
        m00_axis_tvalid = 1'b0;
        m00_axis_tlast  = 1'b0;
        case (state_reg)
            IDLE: begin
                // On a tie the requester that did not own the last packet wins.
                if (s00_axis_tvalid && s01_axis_tvalid)
                    state_next = last_owner_reg ? OWN0 : OWN1;
                else if (s00_axis_tvalid)
                    state_next = OWN0;
                else if (s01_axis_tvalid)
                    state_next = OWN1;
            end
            OWN0: begin
                m00_axis_tdata  = s00_axis_tdata;
                m00_axis_tstrb  = s00_axis_tstrb;
                m00_axis_tvalid = s00_axis_tvalid;
                m00_axis_tlast  = s00_axis_tlast;
                s00_axis_tready = m00_axis_tready;
                if (s00_axis_tvalid && m00_axis_tready && s00_axis_tlast) begin
                    pkt_done[0]     = 1'b1;
                    last_owner_next = 1'b0;
                    state_next      = s01_axis_tvalid ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                m00_axis_tdata  = s01_axis_tdata;
                m00_axis_tstrb  = s01_axis_tstrb;
                m00_axis_tvalid = s01_axis_tvalid;
                m00_axis_tlast  = s01_axis_tlast;
                s01_axis_tready = m00_axis_tready;
                if (s01_axis_tvalid && m00_axis_tready && s01_axis_tlast) begin
                    pkt_done[1]     = 1'b1;
                    last_owner_next = 1'b1;
                    state_next      = s00_axis_tvalid ? OWN0 : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign grant = state_reg;

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [CNT_WIDTH-1:0] count_reg;
        always_ff @(posedge axis_aclk or posedge axis_areset) begin
            if (axis_areset)
                count_reg <= '0;
            else if (pkt_done[gi])
                count_reg <= count_reg + CNT_WIDTH'(1);
        end
    end

    assign pkt_count0 = g_cnt[0].count_reg;
    assign pkt_count1 = g_cnt[1].count_reg;

endmodule

// File: tb/tb_axis_mem_write_arbiter.sv
// Scoreboard bench for axis_mem_write_arbiter: queued packet drivers, a packet-level
// arbitration model and a monitor that checks every cycle against it.
module tb_axis_mem_write_arbiter;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic          l;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [DW-1:0] sd [2];
    logic [SW-1:0] ss [2];
    logic          sv [2];
    logic          sl [2];
    logic          rdy [2];
    logic          rdy2 [2];
    logic [DW-1:0] m_data, m_data2;
    logic [SW-1:0] m_strb, m_strb2;
    logic          m_valid, m_valid2, m_last, m_last2;
    logic          m_ready;
    logic [1:0]    grant, grant2;
    logic [15:0]   cnt0, cnt1;
    logic [1:0]    c20, c21;

    axis_mem_write_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
        .axis_aclk(clk), .axis_areset(rst),
        .s00_axis_tdata(sd[0]), .s00_axis_tstrb(ss[0]), .s00_axis_tvalid(sv[0]),
        .s00_axis_tlast(sl[0]), .s00_axis_tready(rdy[0]),
        .s01_axis_tdata(sd[1]), .s01_axis_tstrb(ss[1]), .s01_axis_tvalid(sv[1]),
        .s01_axis_tlast(sl[1]), .s01_axis_tready(rdy[1]),
        .m00_axis_tdata(m_data), .m00_axis_tstrb(m_strb), .m00_axis_tvalid(m_valid),
        .m00_axis_tlast(m_last), .m00_axis_tready(m_ready),
        .grant(grant), .pkt_count0(cnt0), .pkt_count1(cnt1)
    );

    // Narrow-counter instance sharing all inputs, used for the wrap behaviour.
    axis_mem_write_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(2)) dut2 (
        .axis_aclk(clk), .axis_areset(rst),
        .s00_axis_tdata(sd[0]), .s00_axis_tstrb(ss[0]), .s00_axis_tvalid(sv[0]),
        .s00_axis_tlast(sl[0]), .s00_axis_tready(rdy2[0]),
        .s01_axis_tdata(sd[1]), .s01_axis_tstrb(ss[1]), .s01_axis_tvalid(sv[1]),
        .s01_axis_tlast(sl[1]), .s01_axis_tready(rdy2[1]),
        .m00_axis_tdata(m_data2), .m00_axis_tstrb(m_strb2), .m00_axis_tvalid(m_valid2),
        .m00_axis_tlast(m_last2), .m00_axis_tready(m_ready),
        .grant(grant2), .pkt_count0(c20), .pkt_count1(c21)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    beat_t src_q [2][$];
    beat_t exp_q [2][$];
    int    order_q [$];
    int    ready_mode = 0;
    bit    rnd_gaps = 1'b0;

    task automatic push_beat(input int r, input logic [DW-1:0] d, input logic [SW-1:0] s, input logic l);
        beat_t b;
        b.d = d; b.s = s; b.l = l;
        src_q[r].push_back(b);
        exp_q[r].push_back(b);
    endtask

    task automatic push_rand_pkt(input int r, input int len);
        for (int i = 0; i < len; i++)
            push_beat(r, $urandom, SW'($urandom), i == len - 1);
    endtask

    // Producers: present the head beat, pop it after a handshake.
    for (genvar gi = 0; gi < 2; gi++) begin : g_drv
        initial begin
            sv[gi] = 1'b0; sd[gi] = '0; ss[gi] = '0; sl[gi] = 1'b0;
            forever begin
                @(negedge clk);
                if (!rst && src_q[gi].size() > 0 && !(rnd_gaps && $urandom_range(0, 3) == 0)) begin
                    sv[gi] = 1'b1;
                    sd[gi] = src_q[gi][0].d;
                    ss[gi] = src_q[gi][0].s;
                    sl[gi] = src_q[gi][0].l;
                end else begin
                    sv[gi] = 1'b0;
                    sd[gi] = $urandom;
                    ss[gi] = '0;
                    sl[gi] = 1'($urandom_range(0, 1));
                end
                #4;
                if (sv[gi] && rdy[gi] && src_q[gi].size() > 0)
                    void'(src_q[gi].pop_front());
            end
        end
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ~m_ready;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Reference: owner -1 = none; ties go to the requester that did not finish last.
    int m_owner;
    int m_last_own;
    int m_cnt [2];
    bit first_beat [2];

    initial begin
        beat_t b;
        int o;
        m_owner = -1; m_last_own = 1; m_cnt = '{0, 0}; first_beat = '{1'b1, 1'b1};
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                m_owner = -1; m_last_own = 1; m_cnt = '{0, 0}; first_beat = '{1'b1, 1'b1};
                continue;
            end
            chk("grant", grant, m_owner < 0 ? 2'b00 : (m_owner == 0 ? 2'b01 : 2'b10));
            chk("s00_tready", rdy[0], (m_owner == 0) && m_ready);
            chk("s01_tready", rdy[1], (m_owner == 1) && m_ready);
            chk("m00_tvalid", m_valid, m_owner < 0 ? 1'b0 : sv[m_owner]);
            chk("pkt_count0", cnt0, 64'(m_cnt[0] % 65536));
            chk("pkt_count1", cnt1, 64'(m_cnt[1] % 65536));
            chk("pkt_count0_w2", c20, 64'(m_cnt[0] % 4));
            chk("pkt_count1_w2", c21, 64'(m_cnt[1] % 4));
            chk("dut2_agree", {m_data2, m_strb2, m_valid2, m_last2, rdy2[0], rdy2[1], grant2},
                              {m_data, m_strb, m_valid, m_last, rdy[0], rdy[1], grant});
            if (m_owner < 0) begin
                chk("idle_m00", {m_data, m_strb, m_last}, '0);
                if (sv[0] && sv[1]) m_owner = 1 - m_last_own;
                else if (sv[0])     m_owner = 0;
                else if (sv[1])     m_owner = 1;
            end else if (sv[m_owner] && m_ready) begin
                o = m_owner;
                if (exp_q[o].size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    b = exp_q[o].pop_front();
                    chk("m00_beat", {m_data, m_strb, m_last}, {b.d, b.s, b.l});
                    if (first_beat[o] && order_q.size() > 0)
                        chk("pkt_order", 64'(o), 64'(order_q.pop_front()));
                    first_beat[o] = b.l;
                    if (b.l) begin
                        m_cnt[o]++;
                        m_last_own = o;
                        m_owner = sv[1 - o] ? 1 - o : -1;
                    end
                end
            end
        end
    end

    task automatic drain();
        int n = 0;
        while ((exp_q[0].size() + exp_q[1].size() + src_q[0].size() + src_q[1].size()) != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) chk("drain_timeout", 1, 0);
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        src_q[0].delete(); src_q[1].delete();
        exp_q[0].delete(); exp_q[1].delete();
        order_q.delete();
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_grant"}, grant, 2'b00);
        chk({tag, "_treadys"}, {rdy[0], rdy[1]}, 2'b00);
        chk({tag, "_m00"}, {m_valid, m_last, m_data, m_strb}, '0);
        chk({tag, "_counts"}, {cnt0, cnt1}, '0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Single requester, three beats, grant one cycle after tvalid.
        @(posedge clk); #1;
        push_beat(0, 32'h0055, 4'hF, 1'b0);
        push_beat(0, 32'h0022, 4'hF, 1'b0);
        push_beat(0, 32'h0024, 4'hF, 1'b1);
        @(negedge clk); #1;
        chk("latency_pre", grant, 2'b00);
        @(negedge clk); #1;
        chk("latency_grant", grant, 2'b01);
        drain();
        chk("A_count0", cnt0, 16'd1);
        chk("A_grant_idle", grant, 2'b00);

        // Simultaneous requests from reset: 0 then 1 with no idle gap.
        do_reset();
        @(posedge clk); #1;
        push_beat(0, 32'hB0, 4'hF, 1'b0);
        push_beat(0, 32'hB1, 4'h3, 1'b1);
        push_beat(1, 32'hA1, 4'hF, 1'b0);
        push_beat(1, 32'hA2, 4'hC, 1'b1);
        order_q.push_back(0);
        order_q.push_back(1);
        drain();
        chk("B_counts", {cnt0, cnt1}, {16'd1, 16'd1});

        // Continuous single-beat packets alternate strictly.
        do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            push_beat(0, 32'hC000 + i, 4'hF, 1'b1);
            push_beat(1, 32'hD000 + i, 4'hF, 1'b1);
            order_q.push_back(0);
            order_q.push_back(1);
        end
        drain();
        chk("C_counts", {cnt0, cnt1}, {16'd4, 16'd4});

        // Backpressure toggling on a four-beat packet from requester 1.
        ready_mode = 1;
        @(posedge clk); #1;
        push_rand_pkt(1, 4);
        drain();
        ready_mode = 0;
        chk("D_count1", cnt1, 16'd5);

        // Counter wrap on the 2-bit instance.
        do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) push_rand_pkt(0, 1 + (i % 2));
        drain();
        chk("E_count0", cnt0, 16'd5);
        chk("E_count0_w2", c20, 2'd1);

        // Randomized traffic with gaps and random backpressure.
        rnd_gaps = 1'b1;
        ready_mode = 2;
        @(posedge clk); #1;
        for (int i = 0; i < 30; i++) begin
            push_rand_pkt(0, $urandom_range(1, 4));
            push_rand_pkt(1, $urandom_range(1, 4));
        end
        drain();
        rnd_gaps = 1'b0;
        ready_mode = 0;

        // Reset in the middle of a packet clears everything without a clock edge.
        @(posedge clk); #1;
        push_rand_pkt(0, 6);
        repeat (3) @(negedge clk);
        #1;
        chk("G_mid_grant", grant, 2'b01);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        src_q[0].delete(); src_q[1].delete();
        exp_q[0].delete(); exp_q[1].delete();
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
